fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage pipeline. It owns the fetch PC (PCF), drives a request/ready instruction-memory port, and holds the IF/ID pipeline register feeding decode. It consumes the hazard unit's StallF, StallD and FlushD. It also consumes the branch/jump redirect (PCSrcE, PCTargetE) from execute. It absorbs multi-cycle memory latency by inserting bubbles into decode.

---
 rtl/riscv_pkg.sv | 13 +
 rtl/fetch_stage_if.sv | 24 ++
 rtl/fetch_stage_if_id_reg.sv | 43 ++++
 rtl/fetch_stage.sv | 135 +++++++++++++
 tb/tb_fetch_stage.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: the canonical NOP used for decode bubbles and the
// fetch-stage FSM state encoding.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/ready port between the fetch stage (master) and
// the instruction memory (slave).
interface fetch_stage_if #(
    parameter int word_width = 32
);
    logic                  imem_req;
    logic [word_width-1:0] imem_addr;
    logic                  imem_ready;
    logic [31:0]           imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: StallD hold, FlushD bubble, bubble when no instruction
// was delivered this cycle.
module if_id_reg
    import riscv_pkg::*;
#(
    parameter int word_width = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stallD,
    input  logic                  flushD,
    input  logic                  loadValid,
    input  logic [31:0]           instrIn,
    input  logic [word_width-1:0] pcIn,
    output logic [31:0]           instrD,
    output logic [word_width-1:0] pcD,
    output logic [word_width-1:0] pcPlus4D,
    output logic                  validD
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instrD   <= NOP_INSTR;
            pcD      <= '0;
            pcPlus4D <= '0;
            validD   <= 1'b0;
        end else if (!stallD) begin
            // Stall outranks flush: only an unstalled register can take a bubble.
            if (!flushD && loadValid) begin
                instrD   <= instrIn;
                pcD      <= pcIn;
                pcPlus4D <= pcIn + word_width'(4);
                validD   <= 1'b1;
            end else begin
                instrD   <= NOP_INSTR;
                pcD      <= '0;
                pcPlus4D <= '0;
                validD   <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns PCF, drives the imem request port, absorbs memory
// latency and redirects. Optional FETCH_PERF_EN adds fetched/bubble counters.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int                    word_width = 32,
    parameter logic [word_width-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  StallF,
    input  logic                  StallD,
    input  logic                  FlushD,
    input  logic                  PCSrcE,
    input  logic [word_width-1:0] PCTargetE,
    fetch_stage_if.master         imem,
    output logic [31:0]           InstrD,
    output logic [word_width-1:0] PCD,
    output logic [word_width-1:0] PCPlus4D,
    output logic                  ValidD
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]           perf_fetched,
    output logic [31:0]           perf_bubbles
`endif
);

    fetch_state_t          stateReg, stateNext;
    logic [word_width-1:0] pcReg, pcNext;
    logic [word_width-1:0] tgtReg, tgtNext;
    logic [31:0]           bufReg, bufNext;
    logic                  instrAvail;
    logic [31:0]           instrWord;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg <= FETCH;
            pcReg    <= RESET_PC;
            tgtReg   <= '0;
            bufReg   <= NOP_INSTR;
        end else begin
            stateReg <= stateNext;
            pcReg    <= pcNext;
            tgtReg   <= tgtNext;
            bufReg   <= bufNext;
        end
    end

    always_comb begin
        stateNext  = stateReg;
        pcNext     = pcReg;
        tgtNext    = tgtReg;
        bufNext    = bufReg;
        instrAvail = 1'b0;
        instrWord  = imem.imem_rdata;
        case (stateReg)
            FETCH: begin
                if (PCSrcE) begin
                    if (imem.imem_ready) begin
                        pcNext = PCTargetE;
                    end else begin
                        tgtNext   = PCTargetE;
                        stateNext = DISCARD;
                    end
                end else if (imem.imem_ready) begin
                    if (StallF) begin
                        bufNext   = imem.imem_rdata;
                        stateNext = HOLD;
                    end else begin
                        instrAvail = 1'b1;
                        pcNext     = pcReg + word_width'(4);
                    end
                end
            end
            HOLD: begin
                if (PCSrcE) begin
                    pcNext    = PCTargetE;
                    stateNext = FETCH;
                end else if (!StallF) begin
                    instrAvail = 1'b1;
                    instrWord  = bufReg;
                    pcNext     = pcReg + word_width'(4);
                    stateNext  = FETCH;
                end
            end
            DISCARD: begin
                // The stale request stays on the bus until it completes; only the
                // most recent redirect target survives.
                if (PCSrcE) begin
                    tgtNext = PCTargetE;
                end
                if (imem.imem_ready) begin
                    pcNext    = PCSrcE ? PCTargetE : tgtReg;
                    stateNext = FETCH;
                end
            end
            default: stateNext = FETCH;
        endcase
    end

    assign imem.imem_req  = (stateReg != HOLD);
    assign imem.imem_addr = pcReg;

    if_id_reg #(
        .word_width(word_width)
    ) u_if_id_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .stallD   (StallD),
        .flushD   (FlushD),
        .loadValid(instrAvail),
        .instrIn  (instrWord),
        .pcIn     (pcReg),
        .instrD   (InstrD),
        .pcD      (PCD),
        .pcPlus4D (PCPlus4D),
        .validD   (ValidD)
    );

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_bubbles <= '0;
        end else if (!StallD) begin
            if (!FlushD && instrAvail) begin
                perf_fetched <= perf_fetched + 32'd1;
            end else begin
                perf_bubbles <= perf_bubbles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a variable-latency memory model.
module tb_fetch_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        StallF = 1'b0;
    logic        StallD = 1'b0;
    logic        FlushD = 1'b0;
    logic        PCSrcE = 1'b0;
    logic [31:0] PCTargetE = 32'h0;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
    logic [31:0] memLat = 32'd1;
    logic [31:0] waitCnt;
    int          total = 0;
    int          bad = 0;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubbles;
`endif

    always #5 clk = ~clk;

    fetch_stage_if #(.word_width(32)) bus ();

    fetch_stage #(
        .word_width(32),
        .RESET_PC  (32'h0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .StallF   (StallF),
        .StallD   (StallD),
        .FlushD   (FlushD),
        .PCSrcE   (PCSrcE),
        .PCTargetE(PCTargetE),
        .imem     (bus),
        .InstrD   (InstrD),
        .PCD      (PCD),
        .PCPlus4D (PCPlus4D),
        .ValidD   (ValidD)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_bubbles(perf_bubbles)
`endif
    );

    // Memory answers memLat cycles after the request first appears (1 = same cycle).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) waitCnt <= 32'd0;
        else if (bus.imem_req && !bus.imem_ready) waitCnt <= waitCnt + 32'd1;
        else waitCnt <= 32'd0;
    end
    assign bus.imem_ready = bus.imem_req && (waitCnt == memLat - 32'd1);
    assign bus.imem_rdata = 32'hC000_0000 ^ bus.imem_addr;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return 32'hC000_0000 ^ a;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Leaves time at posedge+4 inside the first post-reset cycle.
    task automatic do_reset(input logic [31:0] lat);
        @(posedge clk);
        #1;
        StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = 0;
        rst_n = 0;
        memLat = lat;
        #2;
        rst_n = 1;
        #1;
    endtask

    task automatic test_reset;
        do_reset(32'd1);
        total++; if (InstrD !== NOP_INSTR) begin bad++; $display("FAIL reset_instr got=%h want=%h", InstrD, NOP_INSTR); end
        total++; if (PCD !== 32'h0) begin bad++; $display("FAIL reset_pcd got=%h want=0", PCD); end
        total++; if (PCPlus4D !== 32'h0) begin bad++; $display("FAIL reset_pcplus4 got=%h want=0", PCPlus4D); end
        total++; if (ValidD !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", ValidD); end
        total++; if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL reset_req got=%b want=1", bus.imem_req); end
        total++; if (bus.imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h want=0", bus.imem_addr); end
        $display("test_reset done");
    endtask

    task automatic test_zero_wait;
        logic [31:0] a;
        do_reset(32'd1);
        for (int i = 0; i < 4; i++) begin
            a = 32'(4 * i);
            total++; if (bus.imem_addr !== a) begin bad++; $display("FAIL zw_addr[%0d] got=%h want=%h", i, bus.imem_addr, a); end
            tick();
            total++; if (InstrD !== memWord(a)) begin bad++; $display("FAIL zw_instr[%0d] got=%h want=%h", i, InstrD, memWord(a)); end
            total++; if (PCD !== a) begin bad++; $display("FAIL zw_pcd[%0d] got=%h want=%h", i, PCD, a); end
            total++; if (PCPlus4D !== a + 32'd4) begin bad++; $display("FAIL zw_pcplus4[%0d] got=%h want=%h", i, PCPlus4D, a + 32'd4); end
            total++; if (ValidD !== 1'b1) begin bad++; $display("FAIL zw_valid[%0d] got=%b want=1", i, ValidD); end
            $display("zero_wait pc=%h instr=%h", PCD, InstrD);
        end
`ifdef FETCH_PERF_EN
        total++; if (perf_fetched !== 32'd4) begin bad++; $display("FAIL perf_fetched got=%0d want=4", perf_fetched); end
        total++; if (perf_bubbles !== 32'd0) begin bad++; $display("FAIL perf_bubbles got=%0d want=0", perf_bubbles); end
`endif
    endtask

    task automatic test_wait3;
        logic [31:0] a;
        do_reset(32'd3);
        for (int i = 0; i < 2; i++) begin
            a = 32'(4 * i);
            for (int j = 0; j < 3; j++) begin
                total++; if (bus.imem_addr !== a) begin bad++; $display("FAIL w3_addr[%0d.%0d] got=%h want=%h", i, j, bus.imem_addr, a); end
                tick();
                total++; if (ValidD !== (j == 2)) begin bad++; $display("FAIL w3_valid[%0d.%0d] got=%b want=%b", i, j, ValidD, (j == 2)); end
                total++; if (InstrD !== ((j == 2) ? memWord(a) : NOP_INSTR)) begin bad++; $display("FAIL w3_instr[%0d.%0d] got=%h", i, j, InstrD); end
            end
            $display("wait3 pc=%h instr=%h", PCD, InstrD);
        end
    endtask

    task automatic test_stall;
        do_reset(32'd1);
        tick();
        tick();
        StallF = 1; StallD = 1;
        tick();
        total++; if (PCD !== 32'h4) begin bad++; $display("FAIL st_hold_pcd got=%h want=4", PCD); end
        total++; if (InstrD !== memWord(32'h4)) begin bad++; $display("FAIL st_hold_instr got=%h want=%h", InstrD, memWord(32'h4)); end
        total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL st_hold_req got=%b want=0", bus.imem_req); end
        FlushD = 1;
        tick();
        total++; if (PCD !== 32'h4) begin bad++; $display("FAIL st_prio_pcd got=%h want=4", PCD); end
        total++; if (ValidD !== 1'b1) begin bad++; $display("FAIL st_prio_valid got=%b want=1", ValidD); end
        StallF = 0; StallD = 0; FlushD = 0;
        tick();
        total++; if (InstrD !== memWord(32'h8)) begin bad++; $display("FAIL st_buf_instr got=%h want=%h", InstrD, memWord(32'h8)); end
        total++; if (PCD !== 32'h8) begin bad++; $display("FAIL st_buf_pcd got=%h want=8", PCD); end
        total++; if (ValidD !== 1'b1) begin bad++; $display("FAIL st_buf_valid got=%b want=1", ValidD); end
        total++; if (bus.imem_addr !== 32'hC) begin bad++; $display("FAIL st_next_addr got=%h want=c", bus.imem_addr); end
        $display("stall pc=%h instr=%h", PCD, InstrD);
    endtask

    task automatic test_redirect;
        do_reset(32'd3);
        PCSrcE = 1; PCTargetE = 32'h100; FlushD = 1;
        tick();
        PCSrcE = 0; FlushD = 0;
        total++; if (ValidD !== 1'b0) begin bad++; $display("FAIL rd_flush_valid got=%b want=0", ValidD); end
        total++; if (InstrD !== NOP_INSTR) begin bad++; $display("FAIL rd_flush_instr got=%h want=%h", InstrD, NOP_INSTR); end
        total++; if (bus.imem_addr !== 32'h0) begin bad++; $display("FAIL rd_stale_addr got=%h want=0", bus.imem_addr); end
        tick();
        tick();
        total++; if (ValidD !== 1'b0) begin bad++; $display("FAIL rd_drop_valid got=%b want=0", ValidD); end
        total++; if (bus.imem_addr !== 32'h100) begin bad++; $display("FAIL rd_new_addr got=%h want=100", bus.imem_addr); end
        tick();
        tick();
        tick();
        total++; if (PCD !== 32'h100) begin bad++; $display("FAIL rd_pcd got=%h want=100", PCD); end
        total++; if (InstrD !== memWord(32'h100)) begin bad++; $display("FAIL rd_instr got=%h want=%h", InstrD, memWord(32'h100)); end
        $display("redirect pc=%h instr=%h", PCD, InstrD);
    endtask

    task automatic test_hold_redirect;
        do_reset(32'd1);
        StallF = 1; StallD = 1;
        tick();
        total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL hr_hold_req got=%b want=0", bus.imem_req); end
        StallF = 0; StallD = 0; PCSrcE = 1; PCTargetE = 32'h100; FlushD = 1;
        tick();
        total++; if (ValidD !== 1'b0) begin bad++; $display("FAIL hr_flush_valid got=%b want=0", ValidD); end
        memLat = 32'd3;
        total++; if (bus.imem_addr !== 32'h100) begin bad++; $display("FAIL hr_addr100 got=%h want=100", bus.imem_addr); end
        PCTargetE = 32'h180;
        tick();
        PCTargetE = 32'h200;
        total++; if (bus.imem_addr !== 32'h100) begin bad++; $display("FAIL hr_disc_addr got=%h want=100", bus.imem_addr); end
        tick();
        PCSrcE = 0; FlushD = 0;
        #1;
        total++; if (bus.imem_ready !== 1'b1) begin bad++; $display("FAIL hr_disc_ready got=%b want=1", bus.imem_ready); end
        tick();
        total++; if (bus.imem_addr !== 32'h200) begin bad++; $display("FAIL hr_resume_addr got=%h want=200", bus.imem_addr); end
        tick();
        tick();
        tick();
        total++; if (PCD !== 32'h200) begin bad++; $display("FAIL hr_pcd got=%h want=200", PCD); end
        total++; if (InstrD !== memWord(32'h200)) begin bad++; $display("FAIL hr_instr got=%h want=%h", InstrD, memWord(32'h200)); end
        total++; if (bus.imem_addr !== 32'h204) begin bad++; $display("FAIL hr_wait_addr got=%h want=204", bus.imem_addr); end
        $display("hold_redirect pc=%h instr=%h", PCD, InstrD);
        // Asynchronous reset in the middle of an outstanding request.
        #2;
        rst_n = 0;
        #1;
        total++; if (InstrD !== NOP_INSTR) begin bad++; $display("FAIL ar_instr got=%h want=%h", InstrD, NOP_INSTR); end
        total++; if (PCD !== 32'h0) begin bad++; $display("FAIL ar_pcd got=%h want=0", PCD); end
        total++; if (PCPlus4D !== 32'h0) begin bad++; $display("FAIL ar_pcplus4 got=%h want=0", PCPlus4D); end
        total++; if (ValidD !== 1'b0) begin bad++; $display("FAIL ar_valid got=%b want=0", ValidD); end
        total++; if (bus.imem_addr !== 32'h0) begin bad++; $display("FAIL ar_addr got=%h want=0", bus.imem_addr); end
        total++; if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL ar_req got=%b want=1", bus.imem_req); end
        rst_n = 1;
        $display("async_reset pc=%h valid=%b", PCD, ValidD);
    endtask

    task automatic test_wrap;
        do_reset(32'd1);
        PCSrcE = 1; PCTargetE = 32'hFFFF_FFFC; FlushD = 1;
        tick();
        PCSrcE = 0; FlushD = 0;
        total++; if (ValidD !== 1'b0) begin bad++; $display("FAIL wr_drop_valid got=%b want=0", ValidD); end
        total++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wr_addr got=%h want=fffffffc", bus.imem_addr); end
        tick();
        total++; if (PCD !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wr_pcd got=%h want=fffffffc", PCD); end
        total++; if (PCPlus4D !== 32'h0) begin bad++; $display("FAIL wr_pcplus4 got=%h want=0", PCPlus4D); end
        total++; if (InstrD !== memWord(32'hFFFF_FFFC)) begin bad++; $display("FAIL wr_instr got=%h want=%h", InstrD, memWord(32'hFFFF_FFFC)); end
        total++; if (bus.imem_addr !== 32'h0) begin bad++; $display("FAIL wr_next_addr got=%h want=0", bus.imem_addr); end
        $display("wrap pc=%h pcplus4=%h", PCD, PCPlus4D);
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait3();
        test_stall();
        test_redirect();
        test_hold_redirect();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
